// File: rtl/inst_src_arbiter.sv
// Round-robin arbiter sharing the decoder instruction input among NUM_SRC sources; one registered output stage, 1-cycle latency, no bubble on drain+refill.
// Optional INST_ARB_ETH_PRIO_EN gives the ethernet source (NUM_SRC-1) strict priority over the core round-robin.
module inst_src_arbiter #(
  parameter int NUM_SRC      = 5,
  parameter int SRC_ID_W     = 3,
  parameter int DATA_WIDTH   = 512,
  parameter int LOAD_INS_LEN = 96,
  parameter int SAVE_INS_LEN = 128
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_SRC-1:0]            req_valid,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] req_data,
  output logic [NUM_SRC-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [SRC_ID_W-1:0]           out_src,
  output logic                          out_is_save,
  input  logic                          out_ready,
  output logic                          busy
);

`ifdef INST_ARB_ETH_PRIO_EN
  localparam int RR_N = NUM_SRC - 1;
`else
  localparam int RR_N = NUM_SRC;
`endif

  logic [SRC_ID_W-1:0]   rr_ptr;
  logic [SRC_ID_W-1:0]   grant_idx;
  logic [SRC_ID_W-1:0]   rr_next;
  logic                  grant_vld;
  logic                  ptr_upd;
  logic                  load_en;
  logic                  take;
  logic [DATA_WIDTH-1:0] src_word [NUM_SRC];
  logic [DATA_WIDTH-1:0] grant_word;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
    assign src_word[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end

  // First valid index among sources 0..n-1, scanning upward from start with wrap.
  function automatic logic [SRC_ID_W-1:0] rr_pick(input logic [NUM_SRC-1:0] v,
                                                  input logic [SRC_ID_W-1:0] start,
                                                  input int n);
    logic [SRC_ID_W-1:0] pick;
    logic                hit;
    int                  idx;
    pick = '0;
    hit  = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (k < n && !hit) begin
        idx = (int'(start) + k) % n;
        if (v[idx]) begin
          hit  = 1'b1;
          pick = SRC_ID_W'(idx);
        end
      end
    end
    return pick;
  endfunction

`ifdef INST_ARB_ETH_PRIO_EN
  logic eth_win;
  assign eth_win   = req_valid[NUM_SRC-1];
  assign grant_idx = eth_win ? SRC_ID_W'(NUM_SRC-1) : rr_pick(req_valid, rr_ptr, RR_N);
  assign ptr_upd   = !eth_win;
`else
  assign grant_idx = rr_pick(req_valid, rr_ptr, RR_N);
  assign ptr_upd   = 1'b1;
`endif

  assign grant_vld  = |req_valid;
  assign load_en    = !out_valid || out_ready;
  assign take       = load_en && grant_vld && !rst;
  assign grant_word = src_word[grant_idx];
  assign rr_next    = (grant_idx == SRC_ID_W'(RR_N-1)) ? '0 : grant_idx + 1'b1;
  assign busy       = grant_vld || out_valid;

  always_comb begin
    req_ready = '0;
    if (take) req_ready[grant_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_src     <= '0;
      out_is_save <= 1'b0;
      rr_ptr      <= '0;
    end else if (take) begin
      out_valid   <= 1'b1;
      out_data    <= grant_word;
      out_src     <= grant_idx;
      out_is_save <= |grant_word[SAVE_INS_LEN-1:LOAD_INS_LEN];
      if (ptr_upd) rr_ptr <= rr_next;
    end else if (out_valid && out_ready) begin
      // drained with nothing to refill: payload fields hold their last value
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inst_src_arbiter.sv
// Bench for inst_src_arbiter: directed scenarios then random traffic, checked against an arithmetic reference model.
module tb_inst_src_arbiter;
  localparam int NS = 5;
  localparam int IW = 3;
  localparam int DW = 512;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS-1:0]    req_valid;
  logic [NS*DW-1:0] req_data;
  logic [NS-1:0]    req_ready;
  logic             out_valid;
  logic [DW-1:0]    out_data;
  logic [IW-1:0]    out_src;
  logic             out_is_save;
  logic             out_ready;
  logic             busy;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] w [NS];
  logic          m_vld;
  logic [DW-1:0] m_data;
  int            m_src;
  logic          m_save;
  int            m_ptr;

  inst_src_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .out_valid(out_valid), .out_data(out_data),
    .out_src(out_src), .out_is_save(out_is_save), .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference grant: first valid source scanning up from the pointer with wrap.
  function automatic int model_grant(input logic [NS-1:0] v);
`ifdef INST_ARB_ETH_PRIO_EN
    if (v[NS-1]) return NS-1;
    for (int k = 0; k < NS-1; k++)
      if (v[(m_ptr + k) % (NS-1)]) return (m_ptr + k) % (NS-1);
`else
    for (int k = 0; k < NS; k++)
      if (v[(m_ptr + k) % NS]) return (m_ptr + k) % NS;
`endif
    return -1;
  endfunction

  task automatic rand_words();
    for (int i = 0; i < NS; i++) begin
      for (int j = 0; j < DW/32; j++) w[i][j*32 +: 32] = $urandom;
      if ($urandom_range(0, 1) == 0) w[i][127:96] = '0;
    end
  endtask

  task automatic cycle(input logic r, input logic [NS-1:0] v, input logic ordy);
    int            g;
    logic [NS-1:0] er;
    rst       = r;
    req_valid = v;
    out_ready = ordy;
    for (int i = 0; i < NS; i++) req_data[i*DW +: DW] = w[i];
    #1;
    g  = model_grant(v);
    er = '0;
    if (!r && g >= 0 && (!m_vld || ordy)) er[g] = 1'b1;
    chk("req_ready",   DW'(req_ready),   DW'(er));
    chk("out_valid",   DW'(out_valid),   DW'(m_vld));
    chk("out_src",     DW'(out_src),     DW'(m_src));
    chk("out_data",    out_data,         m_data);
    chk("out_is_save", DW'(out_is_save), DW'(m_save));
    chk("busy",        DW'(busy),        DW'((|v) || m_vld));
    @(posedge clk);
    if (r) begin
      m_vld = 1'b0; m_data = '0; m_src = 0; m_save = 1'b0; m_ptr = 0;
    end else if (g >= 0 && (!m_vld || ordy)) begin
      m_vld  = 1'b1;
      m_data = w[g];
      m_src  = g;
      m_save = |w[g][127:96];
`ifdef INST_ARB_ETH_PRIO_EN
      if (g != NS-1) m_ptr = (g + 1) % (NS-1);
`else
      m_ptr = (g + 1) % NS;
`endif
    end else if (m_vld && ordy) begin
      m_vld = 1'b0;
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; out_ready = 1'b1; req_data = '0;
    m_vld = 1'b0; m_data = '0; m_src = 0; m_save = 1'b0; m_ptr = 0;
    rand_words();
    @(negedge clk);
    // reset state
    cycle(1'b1, 5'b11111, 1'b1);
    cycle(1'b1, 5'b00000, 1'b1);

    // all sources valid, continuous drain
    for (int k = 0; k < 10; k++) begin
      rand_words();
      cycle(1'b0, 5'b11111, 1'b1);
    end
    cycle(1'b0, 5'b00000, 1'b1);

    // SAVE/LOAD classification on source 2
    rand_words(); w[2][127:96] = 32'h1;
    cycle(1'b0, 5'b00100, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);
    rand_words(); w[2][127:96] = 32'h0;
    cycle(1'b0, 5'b00100, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);

    // stall with sources 1 and 3 waiting
    rand_words();
    cycle(1'b0, 5'b00001, 1'b1);
    for (int k = 0; k < 4; k++) cycle(1'b0, 5'b01010, 1'b0);
    cycle(1'b0, 5'b01010, 1'b1);
    cycle(1'b0, 5'b01000, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);

    // pointer wrap after a source-3 grant
    rand_words();
    cycle(1'b0, 5'b01000, 1'b1);
    cycle(1'b0, 5'b10001, 1'b1);
    cycle(1'b0, 5'b00001, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);

    // reset during a stalled output
    rand_words();
    cycle(1'b0, 5'b00100, 1'b1);
    cycle(1'b0, 5'b11111, 1'b0);
    cycle(1'b1, 5'b11111, 1'b0);
    cycle(1'b0, 5'b11111, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);

`ifdef INST_ARB_ETH_PRIO_EN
    // ethernet starves cores, then core order resumes
    for (int k = 0; k < 6; k++) cycle(1'b0, 5'b11111, 1'b1);
    for (int k = 0; k < 6; k++) cycle(1'b0, 5'b01111, 1'b1);
    cycle(1'b0, 5'b00000, 1'b1);
`endif

    // random traffic with occasional reset
    for (int k = 0; k < 400; k++) begin
      rand_words();
      cycle(($urandom_range(0, 99) == 0), NS'($urandom), ($urandom_range(0, 3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
